// File: rtl/sdram_write_buffer_pkg.sv
// Shared types and constants for the SDRAM write staging buffer.
package sdram_write_buffer_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MASK_W  = 4;
   localparam int unsigned ENTRY_W = MASK_W + DATA_W;
   localparam int unsigned SIZE_W  = 24;

   // DQM polarity: 1 means a set mask bit suppresses the byte on the SDRAM bus.
   localparam bit DQM_MASK_ACTIVE_HIGH = 1'b1;

   typedef enum logic [1:0] {
      BUF_EMPTY    = 2'd0,
      BUF_FILLING  = 2'd1,
      BUF_FULL     = 2'd2,
      BUF_DRAINING = 2'd3
   } buf_state_e;

   typedef struct packed {
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] data;
   } buf_entry_t;

   // Map the front-end byte mask to the DQM level stored with each word.
   function automatic logic [MASK_W-1:0] to_dqm(input logic [MASK_W-1:0] m);
      return DQM_MASK_ACTIVE_HIGH ? m : ~m;
   endfunction

endpackage

// File: rtl/sdram_write_buffer_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdram_write_buffer_dpram
   import sdram_write_buffer_pkg::*;
#(
   parameter int unsigned AW = 8
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  buf_entry_t    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output buf_entry_t    o_rdata
);

   localparam int unsigned WORDS = 2 ** AW;

   buf_entry_t r_mem [WORDS];
   buf_entry_t r_rdata;

   // Storage array, written by the fill side.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; cleared by reset so the output starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sdram_write_buffer.sv
// Two-bank ping-pong write staging buffer feeding the SDRAM write engine.
module sdram_write_buffer
   import sdram_write_buffer_pkg::*;
#(
   parameter int unsigned DEPTH_BITS = 7
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_stb,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [MASK_W-1:0]   in_mask,
   input  logic                in_flush,
   output logic                in_ready,
   output logic [ENTRY_W-1:0]  fifo_data,
   input  logic                fifo_read,
   output logic                fifo_ready,
   input  logic                fifo_activate,
   output logic [SIZE_W-1:0]   fifo_size,
   output logic                overflow
);

   localparam int unsigned IW = DEPTH_BITS;
   localparam int unsigned CW = DEPTH_BITS + 1;
   localparam int unsigned AW = DEPTH_BITS + 1;
   localparam logic [CW-1:0] BANK_WORDS = CW'(2 ** DEPTH_BITS);

   // Registered state
   buf_state_e      r_state [2];
   logic [CW-1:0]   r_count [2];
   logic            r_fill_ptr;
   logic            r_drain_ptr;
   logic            r_act_d;
   logic [IW-1:0]   r_rd_idx;
   logic            r_overflow;
   logic            r_in_ready;
   logic            r_full_drain;
   logic [CW-1:0]   r_size;

   // Next-state values
   buf_state_e      w_state_nx [2];
   logic [CW-1:0]   w_count_nx [2];
   logic            w_fill_ptr_nx;
   logic            w_drain_ptr_nx;
   logic [IW-1:0]   w_rd_idx_nx;
   logic            w_overflow_nx;
   logic            w_in_ready_nx;
   logic            w_full_drain_nx;
   logic [CW-1:0]   w_size_nx;

   // Datapath helpers
   logic            w_accept;
   logic [CW-1:0]   w_fill_cnt;
   logic            w_fill_open;
   logic            w_commit;
   buf_state_e      w_db_state;
   logic            w_claim;
   logic            w_release;
   logic [AW-1:0]   w_waddr;
   logic [AW-1:0]   w_raddr;
   buf_entry_t      w_wdata;
   buf_entry_t      w_rdata;

   assign w_accept    = in_stb && r_in_ready;
   assign w_fill_open = (r_state[r_fill_ptr] == BUF_EMPTY) || (r_state[r_fill_ptr] == BUF_FILLING);
   assign w_fill_cnt  = r_count[r_fill_ptr] + CW'(w_accept);
   assign w_commit    = w_fill_open &&
                        ((w_fill_cnt == BANK_WORDS) || (in_flush && (w_fill_cnt != '0)));
   assign w_db_state  = r_state[r_drain_ptr];
   // Claim is level-based so an early activate waits for the commit.
   assign w_claim     = (w_db_state == BUF_FULL) && fifo_activate;
   assign w_release   = (w_db_state == BUF_DRAINING) && r_act_d && !fifo_activate;

   // Bank state, pointer, read index and output next-state logic.
   always_comb begin
      w_state_nx      = r_state;
      w_count_nx      = r_count;
      w_fill_ptr_nx   = r_fill_ptr;
      w_drain_ptr_nx  = r_drain_ptr;
      w_rd_idx_nx     = r_rd_idx;
      w_overflow_nx   = r_overflow;

      if (w_accept) begin
         w_count_nx[r_fill_ptr] = w_fill_cnt;
         w_state_nx[r_fill_ptr] = BUF_FILLING;
      end
      if (w_commit) begin
         w_state_nx[r_fill_ptr] = BUF_FULL;
         w_fill_ptr_nx          = ~r_fill_ptr;
      end

      // The drain bank is never the open fill bank, so these never collide with the fill updates.
      if (w_claim) begin
         w_state_nx[r_drain_ptr] = BUF_DRAINING;
         w_rd_idx_nx             = '0;
      end else if (w_release) begin
         w_state_nx[r_drain_ptr] = BUF_EMPTY;
         w_count_nx[r_drain_ptr] = '0;
         w_drain_ptr_nx          = ~r_drain_ptr;
      end else if ((w_db_state == BUF_DRAINING) && fifo_read) begin
         if ((CW'(r_rd_idx) + CW'(1)) >= r_count[r_drain_ptr]) begin
            w_overflow_nx = 1'b1;
         end else begin
            w_rd_idx_nx = r_rd_idx + IW'(1);
         end
      end

      w_in_ready_nx   = ((w_state_nx[w_fill_ptr_nx] == BUF_EMPTY) ||
                         (w_state_nx[w_fill_ptr_nx] == BUF_FILLING)) &&
                        (w_count_nx[w_fill_ptr_nx] < BANK_WORDS);
      w_full_drain_nx = (w_state_nx[w_drain_ptr_nx] == BUF_FULL);
      w_size_nx       = ((w_state_nx[w_drain_ptr_nx] == BUF_FULL) ||
                         (w_state_nx[w_drain_ptr_nx] == BUF_DRAINING)) ?
                        w_count_nx[w_drain_ptr_nx] : '0;
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            r_state[b] <= BUF_EMPTY;
            r_count[b] <= '0;
         end
         r_fill_ptr   <= 1'b0;
         r_drain_ptr  <= 1'b0;
         r_act_d      <= 1'b0;
         r_rd_idx     <= '0;
         r_overflow   <= 1'b0;
         r_in_ready   <= 1'b1;
         r_full_drain <= 1'b0;
         r_size       <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            r_state[b] <= w_state_nx[b];
            r_count[b] <= w_count_nx[b];
         end
         r_fill_ptr   <= w_fill_ptr_nx;
         r_drain_ptr  <= w_drain_ptr_nx;
         r_act_d      <= fifo_activate;
         r_rd_idx     <= w_rd_idx_nx;
         r_overflow   <= w_overflow_nx;
         r_in_ready   <= w_in_ready_nx;
         r_full_drain <= w_full_drain_nx;
         r_size       <= w_size_nx;
      end
   end

   // Bank select is the RAM address MSB; read follows the next-state index for fall-through.
   assign w_waddr      = {r_fill_ptr, r_count[r_fill_ptr][IW-1:0]};
   assign w_raddr      = {r_drain_ptr, w_rd_idx_nx};
   assign w_wdata.mask = to_dqm(in_mask);
   assign w_wdata.data = in_data;

   sdram_write_buffer_dpram #(
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst),
      .i_we    (w_accept),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign in_ready   = r_in_ready;
   assign fifo_data  = w_rdata;
   // Drops in the same cycle the engine raises activate.
   assign fifo_ready = r_full_drain && !fifo_activate;
   assign fifo_size  = SIZE_W'(r_size);
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Self-checking bench for sdram_write_buffer against a block-queue reference model.
module tb_sdram_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_stb;
   logic [31:0] in_data;
   logic [3:0]  in_mask;
   logic        in_flush;
   logic        in_ready;
   logic [35:0] fifo_data;
   logic        fifo_read;
   logic        fifo_ready;
   logic        fifo_activate;
   logic [23:0] fifo_size;
   logic        overflow;

   always #5 clk = ~clk;

   sdram_write_buffer #(.DEPTH_BITS(7)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_stb        (in_stb),
      .in_data       (in_data),
      .in_mask       (in_mask),
      .in_flush      (in_flush),
      .in_ready      (in_ready),
      .fifo_data     (fifo_data),
      .fifo_read     (fifo_read),
      .fifo_ready    (fifo_ready),
      .fifo_activate (fifo_activate),
      .fifo_size     (fifo_size),
      .overflow      (overflow)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: committed words in order, block sizes, the block being filled.
   logic [35:0] m_words [$];
   int          m_sizes [$];
   logic [35:0] m_fill  [$];
   bit          m_claimed;
   bit          m_overflow;
   bit          m_act_prev;
   int          m_idx;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_words.delete();
      m_sizes.delete();
      m_fill.delete();
      m_claimed  = 1'b0;
      m_overflow = 1'b0;
      m_act_prev = 1'b0;
      m_idx      = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit rdy;
      bit acc;
      rdy = (m_sizes.size() < 2);
      acc = in_stb && rdy;
      if (!m_claimed && m_sizes.size() > 0 && fifo_activate) begin
         m_claimed = 1'b1;
         m_idx     = 0;
      end else if (m_claimed && m_act_prev && !fifo_activate) begin
         repeat (m_sizes[0]) void'(m_words.pop_front());
         void'(m_sizes.pop_front());
         m_claimed = 1'b0;
      end else if (m_claimed && fifo_read) begin
         if (m_idx + 1 >= m_sizes[0]) m_overflow = 1'b1;
         else                         m_idx++;
      end
      m_act_prev = fifo_activate;
      if (acc) m_fill.push_back({in_mask, in_data});
      if (rdy && (m_fill.size() == 128 || (in_flush && m_fill.size() > 0))) begin
         foreach (m_fill[i]) m_words.push_back(m_fill[i]);
         m_sizes.push_back(m_fill.size());
         m_fill.delete();
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", 36'(in_ready), 36'(m_sizes.size() < 2));
      chk("fifo_ready", 36'(fifo_ready), 36'(m_sizes.size() > 0 && !m_claimed && !fifo_activate));
      chk("fifo_size", 36'(fifo_size), 36'(m_sizes.size() > 0 ? m_sizes[0] : 0));
      chk("overflow", 36'(overflow), 36'(m_overflow));
      if (m_claimed) chk("fifo_data", fifo_data, m_words[m_idx]);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] m, input bit fl);
      in_stb   = 1'b1;
      in_data  = d;
      in_mask  = m;
      in_flush = fl;
      tick();
      in_stb   = 1'b0;
      in_flush = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"}, 36'(in_ready), 36'(1));
      chk({tag, "_fifo_ready"}, 36'(fifo_ready), 36'(0));
      chk({tag, "_fifo_size"}, 36'(fifo_size), 36'(0));
      chk({tag, "_fifo_data"}, fifo_data, 36'(0));
      chk({tag, "_overflow"}, 36'(overflow), 36'(0));
   endtask

   // Claim the waiting block, pop `reads` entries, then release it.
   task automatic drain(input int reads);
      fifo_activate = 1'b1;
      tick();
      fifo_read = 1'b1;
      repeat (reads) tick();
      fifo_read = 1'b0;
      fifo_activate = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b0;
      in_stb = 1'b0; in_data = '0; in_mask = '0; in_flush = 1'b0;
      fifo_read = 1'b0; fifo_activate = 1'b0;
      model_reset();
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b1;

      // Full 128-word block, drained in order.
      for (int i = 0; i < 128; i++) push(32'h1000 + 32'(i), 4'h0, 1'b0);
      chk("full_ready", 36'(fifo_ready), 36'(1));
      chk("full_size", 36'(fifo_size), 36'(128));
      drain(127);

      // Short flushed block plus over-read.
      for (int i = 0; i < 5; i++) push($urandom, 4'($urandom), 1'b0);
      in_flush = 1'b1; tick(); in_flush = 1'b0;
      chk("flush_size", 36'(fifo_size), 36'(5));
      fifo_activate = 1'b1; tick();
      fifo_read = 1'b1; repeat (6) tick(); fifo_read = 1'b0;
      chk("over_flag", 36'(overflow), 36'(1));
      chk("over_data", fifo_data, m_words[4]);
      fifo_activate = 1'b0; tick();

      // Ping-pong: fill the second bank while draining the first, then block.
      for (int i = 0; i < 128; i++) push($urandom, 4'($urandom), 1'b0);
      fifo_activate = 1'b1;
      for (int i = 0; i < 128; i++) begin
         fifo_read = (i > 0);
         push($urandom, 4'($urandom), 1'b0);
      end
      fifo_read = 1'b0;
      push(32'hDEAD_0257, 4'h0, 1'b0);
      chk("blocked_ready", 36'(in_ready), 36'(0));
      fifo_activate = 1'b0; tick();
      chk("unblocked_ready", 36'(in_ready), 36'(1));
      drain(127);

      // Flush coinciding with the last word.
      for (int i = 0; i < 3; i++) push($urandom, 4'($urandom), 1'b0);
      push(32'hCAFE_0003, 4'hC, 1'b1);
      chk("coflush_size", 36'(fifo_size), 36'(4));
      fifo_activate = 1'b1; tick();
      fifo_read = 1'b1; repeat (3) tick(); fifo_read = 1'b0;
      chk("coflush_entry3", fifo_data, {4'hC, 32'hCAFE_0003});
      fifo_activate = 1'b0; tick();

      // Flush on an empty bank does nothing.
      in_flush = 1'b1; tick(); in_flush = 1'b0; tick();
      chk("empty_flush_ready", 36'(fifo_ready), 36'(0));
      chk("empty_flush_size", 36'(fifo_size), 36'(0));

      // Reset in the middle of a drain.
      for (int i = 0; i < 10; i++) push($urandom, 4'($urandom), 1'b0);
      in_flush = 1'b1; tick(); in_flush = 1'b0;
      fifo_activate = 1'b1; tick();
      fifo_read = 1'b1; repeat (3) tick(); fifo_read = 1'b0;
      rst = 1'b0;
      #1;
      check_reset_values("midrst");
      model_reset();
      fifo_activate = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("midrst_hold");
      rst = 1'b1;
      push(32'h0000_AAAA, 4'h1, 1'b0);
      push(32'h0000_BBBB, 4'h2, 1'b1);
      chk("post_rst_size", 36'(fifo_size), 36'(2));
      fifo_activate = 1'b1; tick();
      chk("post_rst_e0", fifo_data, {4'h1, 32'h0000_AAAA});
      fifo_read = 1'b1; tick(); fifo_read = 1'b0;
      chk("post_rst_e1", fifo_data, {4'h2, 32'h0000_BBBB});
      fifo_activate = 1'b0; tick();

      // Randomized traffic on both sides concurrently.
      for (int c = 0; c < 4000; c++) begin
         in_stb   = ($urandom_range(0, 9) < 7);
         in_data  = $urandom;
         in_mask  = 4'($urandom);
         in_flush = ($urandom_range(0, 39) == 0);
         if (!fifo_activate) fifo_activate = ($urandom_range(0, 3) == 0);
         else                fifo_activate = ($urandom_range(0, 59) != 0);
         fifo_read = fifo_activate && ($urandom_range(0, 1) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
